// File: rtl/mem_responder_if.sv
// Bus bundle between the MIPS memory controller (master) and the memory
// responder (slave). Signal names follow the core's datapath naming.
//   req       master -> slave   request strobe
//   MemWrite  master -> slave   1 = write, 0 = read
//   MemMode   master -> slave   00 word, 01 half, 10 byte, 11 reserved
//   addr      master -> slave   byte address
//   wdata     master -> slave   right-justified write data
//   rdata     slave  -> master  zero-extended read data (registered)
//   ready     slave  -> master  one-cycle completion pulse
//   busy      slave  -> master  request outstanding
//   err       slave  -> master  request rejected (pulses with ready)
interface mem_responder_if;
    logic        req;
    logic        MemWrite;
    logic [1:0]  MemMode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output req, MemWrite, MemMode, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  req, MemWrite, MemMode, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle MIPS core. Accepts one
// word/half/byte read or write, completes it LATENCY cycles after the request
// is sampled and signals completion with a one-cycle ready pulse.
// Byte lanes are big-endian: byte offset 0 is bits 31:24.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-low reset; aborts any in-flight request
//   bus    mem_responder_if.slave (see interface file)
//
// state | meaning
// IDLE  | waiting for req; ready/err pulse of the previous request shows here
// WAIT  | latency countdown, count runs down to 0
// RESP  | last busy cycle; its closing edge commits the write / loads rdata
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input logic             clk,
    input logic             reset,
    mem_responder_if.slave  bus
);

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT  = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    localparam logic [1:0]  MODE_WORD  = 2'b00;
    localparam logic [1:0]  MODE_HALF  = 2'b01;
    localparam logic [1:0]  MODE_BYTE  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          count, count_nxt;
    logic                accept;
    logic                resp_done;

    logic                write_q;
    logic [1:0]          mode_q;
    logic [IDX_W+1:0]    addr_q;
    logic [31:0]         wdata_q;
    logic                err_q;
    logic                req_err;

    logic [31:0]         mem [DEPTH_WORDS];
    logic [IDX_W-1:0]    idx;
    logic [31:0]         rword;
    logic [31:0]         lane_mask;
    logic [31:0]         lane_data;
    logic [31:0]         rd_lane;
    logic [31:0]         wr_word;
    logic [4:0]          shift;

    logic [31:0]         rdata_r;
    logic                ready_r;
    logic                err_r;

    // Rejection is decided from the live inputs at capture time so only the
    // low address bits needed for indexing have to be stored.
    always_comb begin
        req_err = 1'b0;
        if (bus.MemMode == 2'b11)
            req_err = 1'b1;
        if (bus.MemMode == MODE_WORD && bus.addr[1:0] != 2'b00)
            req_err = 1'b1;
        if (bus.MemMode == MODE_HALF && bus.addr[0])
            req_err = 1'b1;
        if (bus.addr >= ADDR_LIMIT)
            req_err = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            count <= 4'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        accept    = 1'b0;
        resp_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    accept = 1'b1;
                    if (LATENCY <= 1) begin
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_WAIT;
                        count_nxt = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (count == 4'd0)
                    state_nxt = ST_RESP;
                else
                    count_nxt = count - 4'd1;
            end
            ST_RESP: begin
                resp_done = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_q <= 1'b0;
            mode_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            write_q <= bus.MemWrite;
            mode_q  <= bus.MemMode;
            addr_q  <= bus.addr[IDX_W+1:0];
            wdata_q <= bus.wdata;
            err_q   <= req_err;
        end
    end

    // Index is only meaningful when err_q is clear; rejected requests never
    // write and never expose rword.
    assign idx   = addr_q[IDX_W+1:2];
    assign rword = mem[idx];

    // Lane shift counts from the LSB: big-endian offset 0 sits at bit 24.
    always_comb begin
        lane_mask = 32'd0;
        lane_data = 32'd0;
        rd_lane   = 32'd0;
        shift     = 5'd0;
        case (mode_q)
            MODE_WORD: begin
                lane_mask = 32'hFFFF_FFFF;
                lane_data = wdata_q;
                rd_lane   = rword;
            end
            MODE_HALF: begin
                shift     = {~addr_q[1], 4'b0000};
                lane_mask = 32'h0000_FFFF << shift;
                lane_data = {16'h0000, wdata_q[15:0]} << shift;
                rd_lane   = (rword >> shift) & 32'h0000_FFFF;
            end
            MODE_BYTE: begin
                shift     = {~addr_q[1:0], 3'b000};
                lane_mask = 32'h0000_00FF << shift;
                lane_data = {24'h000000, wdata_q[7:0]} << shift;
                rd_lane   = (rword >> shift) & 32'h0000_00FF;
            end
            default: ;
        endcase
        wr_word = (rword & ~lane_mask) | (lane_data & lane_mask);
    end

    // Storage is intentionally not reset. resp_done is derived from the
    // asynchronously reset state, so an aborted request can never commit.
    always_ff @(posedge clk) begin
        if (resp_done && write_q && !err_q)
            mem[idx] <= wr_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r <= 32'd0;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ready_r <= resp_done;
            err_r   <= resp_done && err_q;
            if (resp_done) begin
                if (err_q)
                    rdata_r <= 32'd0;
                else if (!write_q)
                    rdata_r <= rd_lane;
            end
        end
    end

    assign bus.rdata = rdata_r;
    assign bus.ready = ready_r;
    assign bus.err   = err_r;
    assign bus.busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          due;
        string       name;
    } exp_t;

    logic clk;
    logic reset;
    int   edge_cnt;
    int   checks;
    int   failures;

    exp_t q0[$];
    exp_t q1[$];

    mem_responder_if bus0();
    mem_responder_if bus1();

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    mem_responder #(.DEPTH_WORDS(16), .LATENCY(LAT1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic r, input logic w,
                         input logic [1:0] m, input logic [31:0] a, input logic [31:0] d);
        if (which == 0) begin
            bus0.req = r; bus0.MemWrite = w; bus0.MemMode = m; bus0.addr = a; bus0.wdata = d;
        end else begin
            bus1.req = r; bus1.MemWrite = w; bus1.MemMode = m; bus1.addr = a; bus1.wdata = d;
        end
    endtask

    function automatic logic get_ready(input int which);
        return (which == 0) ? bus0.ready : bus1.ready;
    endfunction

    function automatic logic get_busy(input int which);
        return (which == 0) ? bus0.busy : bus1.busy;
    endfunction

    // Called at a negedge. Response data is checked by the monitors; this task
    // checks that a ready arrives and how long busy was high.
    task automatic issue(input int which, input logic w, input logic [1:0] m,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err, input string name);
        exp_t e;
        int   lat;
        int   n;
        int   bc;
        logic rdy;
        lat    = (which == 0) ? LAT0 : LAT1;
        e.rd   = exp_rd;
        e.err  = exp_err;
        e.due  = edge_cnt + 1 + lat;
        e.name = name;
        if (which == 0) q0.push_back(e); else q1.push_back(e);
        drive(which, 1'b1, w, m, a, d);
        @(negedge clk);
        // scramble the inputs: the request must already be latched
        drive(which, 1'b0, ~w, ~m, 32'hFFFF_FFFF, 32'h5A5A_5A5A);
        bc  = 0;
        n   = 0;
        rdy = get_ready(which);
        while (!rdy && n < 32) begin
            if (get_busy(which)) bc++;
            @(negedge clk);
            n++;
            rdy = get_ready(which);
        end
        chk({name, " ready_seen"}, 32'(rdy), 32'd1);
        chk({name, " busy_cycles"}, 32'(bc), 32'(lat));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && bus0.ready) begin
            if (q0.size() == 0) begin
                chk("dut0 unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk({e.name, " rdata"}, bus0.rdata, e.rd);
                chk({e.name, " err"}, 32'(bus0.err), 32'(e.err));
                chk({e.name, " ready_edge"}, 32'(edge_cnt), 32'(e.due));
            end
        end
        if (reset && !bus0.ready && bus0.err)
            chk("dut0 err_without_ready", 32'd1, 32'd0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset && bus1.ready) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk({e.name, " rdata"}, bus1.rdata, e.rd);
                chk({e.name, " err"}, 32'(bus1.err), 32'(e.err));
                chk({e.name, " ready_edge"}, 32'(edge_cnt), 32'(e.due));
            end
        end
    end

    initial begin
        int e0;
        int n;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("reset ready", 32'(bus0.ready), 32'd0);
        chk("reset busy",  32'(bus0.busy),  32'd0);
        chk("reset err",   32'(bus0.err),   32'd0);
        chk("reset rdata", bus0.rdata,      32'd0);
        reset = 1'b1;
        @(negedge clk);

        // reset mid-WAIT aborts the write
        issue(0, 1'b1, 2'b00, 32'h10, 32'h1111_1111, 32'h0, 1'b0, "prewrite_10");
        drive(0, 1'b1, 1'b1, 2'b00, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        chk("abort busy_before_reset", 32'(bus0.busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort busy_in_reset",  32'(bus0.busy),  32'd0);
        chk("abort ready_in_reset", 32'(bus0.ready), 32'd0);
        chk("abort err_in_reset",   32'(bus0.err),   32'd0);
        repeat (2) @(negedge clk);
        chk("abort ready_held_reset", 32'(bus0.ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        issue(0, 1'b0, 2'b00, 32'h10, 32'h0, 32'h1111_1111, 1'b0, "read_after_abort");

        // word write/read
        issue(0, 1'b1, 2'b00, 32'h20, 32'h1234_5678, 32'h1111_1111, 1'b0, "wr_word_20");
        issue(0, 1'b0, 2'b00, 32'h20, 32'h0, 32'h1234_5678, 1'b0, "rd_word_20");

        // byte/half lanes
        issue(0, 1'b1, 2'b10, 32'h21, 32'h0000_00AB, 32'h1234_5678, 1'b0, "wr_byte_21");
        issue(0, 1'b1, 2'b01, 32'h22, 32'h0000_CDEF, 32'h1234_5678, 1'b0, "wr_half_22");
        issue(0, 1'b0, 2'b00, 32'h20, 32'h0, 32'h12AB_CDEF, 1'b0, "rd_word_20_merged");
        issue(0, 1'b0, 2'b10, 32'h21, 32'h0, 32'h0000_00AB, 1'b0, "rd_byte_21");
        issue(0, 1'b0, 2'b01, 32'h20, 32'h0, 32'h0000_12AB, 1'b0, "rd_half_20");
        issue(0, 1'b0, 2'b10, 32'h23, 32'h0, 32'h0000_00EF, 1'b0, "rd_byte_23");

        // rejected requests
        issue(0, 1'b0, 2'b00, 32'h22, 32'h0, 32'h0, 1'b1, "err_word_misalign");
        issue(0, 1'b0, 2'b01, 32'h23, 32'h0, 32'h0, 1'b1, "err_half_misalign");
        issue(0, 1'b0, 2'b11, 32'h20, 32'h0, 32'h0, 1'b1, "err_mode11");
        issue(0, 1'b0, 2'b00, 32'h400, 32'h0, 32'h0, 1'b1, "err_range_400");
        issue(0, 1'b0, 2'b00, 32'h8000_0020, 32'h0, 32'h0, 1'b1, "err_range_nowrap");
        issue(0, 1'b1, 2'b00, 32'h21, 32'hFFFF_FFFF, 32'h0, 1'b1, "err_wr_misalign");
        issue(0, 1'b1, 2'b00, 32'h400, 32'hFFFF_FFFF, 32'h0, 1'b1, "err_wr_range");
        issue(0, 1'b1, 2'b01, 32'h23, 32'h0000_FFFF, 32'h0, 1'b1, "err_wr_half");
        issue(0, 1'b0, 2'b00, 32'h20, 32'h0, 32'h12AB_CDEF, 1'b0, "rd_20_after_errs");

        // last valid word
        issue(0, 1'b1, 2'b00, 32'h3FC, 32'hCAFE_F00D, 32'h12AB_CDEF, 1'b0, "wr_word_3fc");
        issue(0, 1'b0, 2'b10, 32'h3FF, 32'h0, 32'h0000_000D, 1'b0, "rd_byte_3ff");
        issue(0, 1'b0, 2'b01, 32'h3FC, 32'h0, 32'h0000_CAFE, 1'b0, "rd_half_3fc");

        // req while busy is ignored
        q0.push_back('{rd: 32'h12AB_CDEF, err: 1'b0, due: edge_cnt + 1 + LAT0, name: "busy_rd_20"});
        drive(0, 1'b1, 1'b0, 2'b00, 32'h20, 32'h0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 2'b00, 32'h20, 32'h0000_0000);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        n = 0;
        while (!bus0.ready && n < 32) begin
            @(negedge clk);
            n++;
        end
        chk("busy_rd_20 ready_seen", 32'(bus0.ready), 32'd1);
        @(negedge clk);
        issue(0, 1'b0, 2'b00, 32'h20, 32'h0, 32'h12AB_CDEF, 1'b0, "rd_20_after_ignored_wr");

        // LATENCY=1 instance: held req, back-to-back reads
        issue(1, 1'b1, 2'b00, 32'h0, 32'hA0A0_A0A0, 32'h0, 1'b0, "l1_wr_0");
        issue(1, 1'b1, 2'b00, 32'h4, 32'hB1B1_B1B1, 32'h0, 1'b0, "l1_wr_4");
        e0 = edge_cnt;
        q1.push_back('{rd: 32'hA0A0_A0A0, err: 1'b0, due: e0 + 2, name: "l1_rd_0a"});
        q1.push_back('{rd: 32'hB1B1_B1B1, err: 1'b0, due: e0 + 4, name: "l1_rd_4"});
        q1.push_back('{rd: 32'hA0A0_A0A0, err: 1'b0, due: e0 + 6, name: "l1_rd_0b"});
        drive(1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("l1_held ready_k%0d", k), 32'(bus1.ready), 32'((k % 2) == 0));
            if (k == 2) bus1.addr = 32'h4;
            if (k == 4) bus1.addr = 32'h0;
        end
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

        repeat (5) @(negedge clk);
        chk("dut0 queue_empty", 32'(q0.size()), 32'd0);
        chk("dut1 queue_empty", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
